// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- hazard and stall controller for the 5-stage core.
//
// Drives a CTRL_Wire_Bus command (00 Default, 01 Block, 10 Bubble) into the
// PC register and the IF_ID / ID_EX / EX_MEM / MEM_WB pipeline registers.
// Priority in RUN: data-memory wait, EX redirect, load-use, fetch wait.
// DROP tracks a wrong-path fetch that is still outstanding after a redirect.
//
// Optional feature macro: PIPE_CTRL_PERF_EN enables the 64-bit stall/flush
// performance counters; when undefined both counter ports are tied to 0.
//
// Parameters:
//   MEM_TIMEOUT    consecutive mem_wait_i cycles that set mem_timeout_o (1..65535)
// Ports:
//   clk, rst                        clock (rising edge), async active-high reset
//   id_rs1_addr_i, id_rs2_addr_i    ID source registers
//   id_rs1_used_i, id_rs2_used_i    ID instruction reads rs1 / rs2
//   ex_rd_addr_i, ex_wreg_i         EX destination register and write enable
//   ex_is_load_i                    EX instruction is a load
//   ex_redirect_i                   taken branch/jump in EX
//   if_wait_i, mem_wait_i           fetch / data-memory access not complete
//   pc_ctrl_o .. mem_wb_ctrl_o      CTRL_Wire_Bus commands (combinational)
//   mem_timeout_o                   sticky memory-timeout flag
//   stall_cnt_o, flush_cnt_o        performance counters
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_wreg_i,
  input  logic        ex_is_load_i,
  input  logic        ex_redirect_i,
  input  logic        if_wait_i,
  input  logic        mem_wait_i,
  output logic [1:0]  pc_ctrl_o,
  output logic [1:0]  if_id_ctrl_o,
  output logic [1:0]  id_ex_ctrl_o,
  output logic [1:0]  ex_mem_ctrl_o,
  output logic [1:0]  mem_wb_ctrl_o,
  output logic        mem_timeout_o,
  output logic [63:0] stall_cnt_o,
  output logic [63:0] flush_cnt_o
);

  localparam logic [1:0]  CTRL_STATE_Default = 2'b00;
  localparam logic [1:0]  CTRL_STATE_Block   = 2'b01;
  localparam logic [1:0]  CTRL_STATE_Bubble  = 2'b10;
  localparam logic [15:0] TIMEOUT_CNT        = 16'(MEM_TIMEOUT);

  typedef enum logic {ST_RUN, ST_DROP} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_inc;
  logic        r_timeout;
  logic        w_lu;

  assign w_lu = ex_is_load_i & ex_wreg_i & (ex_rd_addr_i != 5'd0) &
                ((id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                 (id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i)));

  always_comb begin
    pc_ctrl_o     = CTRL_STATE_Default;
    if_id_ctrl_o  = CTRL_STATE_Default;
    id_ex_ctrl_o  = CTRL_STATE_Default;
    ex_mem_ctrl_o = CTRL_STATE_Default;
    mem_wb_ctrl_o = CTRL_STATE_Default;
    w_state_next  = r_state;
    if (rst) begin
      pc_ctrl_o     = CTRL_STATE_Block;
      if_id_ctrl_o  = CTRL_STATE_Bubble;
      id_ex_ctrl_o  = CTRL_STATE_Bubble;
      ex_mem_ctrl_o = CTRL_STATE_Bubble;
      mem_wb_ctrl_o = CTRL_STATE_Bubble;
      w_state_next  = ST_RUN;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (mem_wait_i) begin
            // Redirect is held off here; EX keeps ex_redirect_i asserted.
            pc_ctrl_o     = CTRL_STATE_Block;
            if_id_ctrl_o  = CTRL_STATE_Block;
            id_ex_ctrl_o  = CTRL_STATE_Block;
            ex_mem_ctrl_o = CTRL_STATE_Block;
            mem_wb_ctrl_o = CTRL_STATE_Bubble;
          end else if (ex_redirect_i) begin
            if_id_ctrl_o  = CTRL_STATE_Bubble;
            id_ex_ctrl_o  = CTRL_STATE_Bubble;
            if (if_wait_i) w_state_next = ST_DROP;
          end else if (w_lu) begin
            pc_ctrl_o     = CTRL_STATE_Block;
            if_id_ctrl_o  = CTRL_STATE_Block;
            id_ex_ctrl_o  = CTRL_STATE_Bubble;
          end else if (if_wait_i) begin
            pc_ctrl_o     = CTRL_STATE_Block;
            if_id_ctrl_o  = CTRL_STATE_Bubble;
          end
        end
        ST_DROP: begin
          // The stale fetch is bubbled on every cycle, including its return.
          pc_ctrl_o    = CTRL_STATE_Block;
          if_id_ctrl_o = CTRL_STATE_Bubble;
          if (mem_wait_i) begin
            id_ex_ctrl_o  = CTRL_STATE_Block;
            ex_mem_ctrl_o = CTRL_STATE_Block;
            mem_wb_ctrl_o = CTRL_STATE_Bubble;
          end
          if (!if_wait_i) w_state_next = ST_RUN;
        end
        default: w_state_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  assign w_wait_inc = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_wait_cnt <= mem_wait_i ? w_wait_inc : '0;
      if (mem_wait_i && (w_wait_inc == TIMEOUT_CNT)) r_timeout <= 1'b1;
    end
  end

  assign mem_timeout_o = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
  logic [63:0] r_stall_cnt;
  logic [63:0] r_flush_cnt;
  logic        w_flush;

  assign w_flush = (r_state == ST_RUN) & ~mem_wait_i & ex_redirect_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (pc_ctrl_o == CTRL_STATE_Block) r_stall_cnt <= r_stall_cnt + 64'd1;
      if (w_flush)                       r_flush_cnt <= r_flush_cnt + 64'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int unsigned TO  = 8;
  localparam logic [1:0]  DEF = 2'b00;
  localparam logic [1:0]  BLK = 2'b01;
  localparam logic [1:0]  BUB = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        u1, u2, ex_wreg, ex_load, redir, if_wait, mem_wait;
  logic [1:0]  pc_c, ifid_c, idex_c, exmem_c, memwb_c;
  logic        mto;
  logic [63:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2),
    .ex_rd_addr_i(ex_rd), .ex_wreg_i(ex_wreg), .ex_is_load_i(ex_load),
    .ex_redirect_i(redir), .if_wait_i(if_wait), .mem_wait_i(mem_wait),
    .pc_ctrl_o(pc_c), .if_id_ctrl_o(ifid_c), .id_ex_ctrl_o(idex_c),
    .ex_mem_ctrl_o(exmem_c), .mem_wb_ctrl_o(memwb_c),
    .mem_timeout_o(mto), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: "stale fetch outstanding" flag, length of the current
  // mem-wait run, sticky timeout, and event tallies for the perf counters.
  bit              m_drop;
  bit              m_to;
  int unsigned     m_run;
  longint unsigned m_stall, m_flush;

  function automatic void model_clear();
    m_drop = 0; m_to = 0; m_run = 0; m_stall = 0; m_flush = 0;
  endfunction

  function automatic logic [9:0] model_ctrl();
    bit reads_rd, lu;
    reads_rd = (u1 && id_rs1 == ex_rd) || (u2 && id_rs2 == ex_rd);
    lu = ex_load && ex_wreg && (ex_rd != 5'd0) && reads_rd;
    if (rst)           return {BLK, BUB, BUB, BUB, BUB};
    if (m_drop)        return mem_wait ? {BLK, BUB, BLK, BLK, BUB} : {BLK, BUB, DEF, DEF, DEF};
    if (mem_wait)      return {BLK, BLK, BLK, BLK, BUB};
    if (redir)         return {DEF, BUB, BUB, DEF, DEF};
    if (lu)            return {BLK, BLK, BUB, DEF, DEF};
    if (if_wait)       return {BLK, BUB, DEF, DEF, DEF};
    return {DEF, DEF, DEF, DEF, DEF};
  endfunction

  function automatic logic [63:0] exp_stall();
`ifdef PIPE_CTRL_PERF_EN
    return m_stall;
`else
    return 64'd0;
`endif
  endfunction

  function automatic logic [63:0] exp_flush();
`ifdef PIPE_CTRL_PERF_EN
    return m_flush;
`else
    return 64'd0;
`endif
  endfunction

  // Advance one clock; model state follows the inputs held across the edge.
  task automatic tick();
    logic [9:0] e;
    e = model_ctrl();
    if (rst) model_clear();
    else begin
      if (e[9:8] == BLK) m_stall++;
      if (!m_drop && !mem_wait && redir) m_flush++;
      if (m_drop) m_drop = if_wait;
      else if (!mem_wait && redir) m_drop = if_wait;
      m_run = mem_wait ? m_run + 1 : 0;
      if (m_run >= TO) m_to = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit mw, input bit rd_, input bit iw, input bit ld,
                       input bit wr, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input bit a1, input bit a2);
    mem_wait = mw; redir = rd_; if_wait = iw; ex_load = ld; ex_wreg = wr;
    ex_rd = rd; id_rs1 = r1; id_rs2 = r2; u1 = a1; u2 = a2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  task automatic test_reset();
    logic [9:0] got;
    rst = 1'b1;
    drive(1, 1, 1, 1, 1, 5'd3, 5'd3, 5'd3, 1, 1);
    model_clear();
    #4;
    got = {pc_c, ifid_c, idex_c, exmem_c, memwb_c};
    total++;
    if (got !== {BLK, BUB, BUB, BUB, BUB}) begin
      bad++; $display("FAIL reset_ctrl got=%h exp=%h", got, {BLK, BUB, BUB, BUB, BUB});
    end
    total++;
    if ({mto, stall_cnt, flush_cnt} !== '0) begin
      bad++; $display("FAIL reset_regs got=%b/%0d/%0d exp=0/0/0", mto, stall_cnt, flush_cnt);
    end
    tick(); tick();
    rst = 1'b0;
    idle();
    #4;
    got = {pc_c, ifid_c, idex_c, exmem_c, memwb_c};
    total++;
    if (got !== 10'd0) begin
      bad++; $display("FAIL reset_release got=%h exp=000", got);
    end
    tick();
  endtask

  // Load x5 then add x6,x5,x1; repeated with rd = 0.
  task automatic test_load_use();
    logic [9:0] got, exp;
    for (int unsigned i = 0; i < 6; i++) begin
      case (i)
        0: drive(0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd1, 1, 1);
        1: drive(0, 0, 0, 0, 1, 5'd6, 5'd5, 5'd1, 1, 1);
        2: idle();
        3: drive(0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd1, 1, 1);
        4: drive(0, 0, 0, 1, 1, 5'd9, 5'd2, 5'd9, 1, 1);
        default: drive(0, 0, 0, 1, 1, 5'd9, 5'd2, 5'd9, 1, 0);
      endcase
      #4;
      got = {pc_c, ifid_c, idex_c, exmem_c, memwb_c};
      exp = model_ctrl();
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL load_use[%0d] got=%h exp=%h", i, got, exp);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_redirect();
    logic [9:0] got, exp;
    for (int unsigned i = 0; i < 2; i++) begin
      if (i == 0) drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      else idle();
      #4;
      got = {pc_c, ifid_c, idex_c, exmem_c, memwb_c};
      exp = model_ctrl();
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL redirect[%0d] got=%h exp=%h", i, got, exp);
      end
      tick();
    end
    total++;
    if (flush_cnt !== exp_flush()) begin
      bad++; $display("FAIL redirect_flush_cnt got=%0d exp=%0d", flush_cnt, exp_flush());
    end
  endtask

  task automatic test_redirect_drop();
    logic [9:0] got, exp;
    for (int unsigned i = 0; i < 6; i++) begin
      if (i == 0)      drive(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      else if (i < 4)  drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      else             idle();
      #4;
      got = {pc_c, ifid_c, idex_c, exmem_c, memwb_c};
      exp = model_ctrl();
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL redirect_drop[%0d] got=%h exp=%h", i, got, exp);
      end
      tick();
    end
    total++;
    if (stall_cnt !== exp_stall()) begin
      bad++; $display("FAIL drop_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall());
    end
  endtask

  task automatic test_mem_redirect();
    logic [9:0] got, exp;
    for (int unsigned i = 0; i < 6; i++) begin
      if (i < 4)       drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      else if (i == 4) drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      else             idle();
      #4;
      got = {pc_c, ifid_c, idex_c, exmem_c, memwb_c};
      exp = model_ctrl();
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL mem_redirect[%0d] got=%h exp=%h", i, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    for (int unsigned n = 0; n < TO - 1; n++) begin
      drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      tick();
    end
    idle();
    #4;
    total++;
    if (mto !== 1'b0) begin
      bad++; $display("FAIL timeout_short got=%b exp=0", mto);
    end
    tick();
    for (int unsigned n = 0; n < TO; n++) begin
      drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      tick();
    end
    idle();
    #4;
    total++;
    if (mto !== 1'b1) begin
      bad++; $display("FAIL timeout_set got=%b exp=1", mto);
    end
    tick(); tick();
    total++;
    if (mto !== 1'b1) begin
      bad++; $display("FAIL timeout_sticky got=%b exp=1", mto);
    end
    rst = 1'b1;
    model_clear();
    tick();
    rst = 1'b0;
    #4;
    total++;
    if (mto !== 1'b0) begin
      bad++; $display("FAIL timeout_rst got=%b exp=0", mto);
    end
    tick();
  endtask

  task automatic test_reset_drop();
    logic [9:0] got;
    drive(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    got = {pc_c, ifid_c, idex_c, exmem_c, memwb_c};
    total++;
    if (got !== {BLK, BUB, BUB, BUB, BUB}) begin
      bad++; $display("FAIL rst_drop_ctrl got=%h exp=%h", got, {BLK, BUB, BUB, BUB, BUB});
    end
    tick();
    rst = 1'b0;
    idle();
    #4;
    got = {pc_c, ifid_c, idex_c, exmem_c, memwb_c};
    total++;
    if (got !== 10'd0) begin
      bad++; $display("FAIL rst_drop_run got=%h exp=000", got);
    end
    total++;
    if ({stall_cnt, flush_cnt} !== '0) begin
      bad++; $display("FAIL rst_drop_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    logic [9:0] got, exp;
    for (int unsigned i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0);
      #4;
      got = {pc_c, ifid_c, idex_c, exmem_c, memwb_c};
      exp = model_ctrl();
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL random_ctrl[%0d] got=%h exp=%h", i, got, exp);
      end
      total++;
      if (mto !== m_to) begin
        bad++; $display("FAIL random_timeout[%0d] got=%b exp=%b", i, mto, m_to);
      end
      total++;
      if (stall_cnt !== exp_stall() || flush_cnt !== exp_flush()) begin
        bad++; $display("FAIL random_cnt[%0d] got=%0d/%0d exp=%0d/%0d",
                        i, stall_cnt, flush_cnt, exp_stall(), exp_flush());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_clear();
    #1;
    test_reset();
    test_load_use();
    test_redirect();
    test_redirect_drop();
    test_mem_redirect();
    test_timeout();
    test_reset_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and stall controller for the 5-stage core. Each cycle it drives the 2-bit `CTRL_Wire_Bus` command (Default/Block/Bubble) into the PC register and into the four pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB). It resolves the following, in fixed priority:
- data-memory wait,
- EX branch/jump redirect,
- load-use hazard,
- instruction-fetch wait.

It also tracks a stale in-flight fetch after a redirect.

## Interface
Parameters:
- `MEM_TIMEOUT`, 256: consecutive `mem_wait_i` cycles after which `mem_timeout_o` sets; range 1..65535.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_rs1_addr_i`, `id_rs2_addr_i`  in  5 each  source registers of the instruction in ID.
- `id_rs1_used_i`, `id_rs2_used_i`  in  1 each  the ID instruction reads rs1 / rs2.
- `ex_rd_addr_i`  in  5  destination register of the instruction in EX.
- `ex_wreg_i`  in  1  the EX instruction writes rd.
- `ex_is_load_i`  in  1  the EX instruction is a load.
- `ex_redirect_i`  in  1  a branch or jump in EX is taken; the PC input carries the target.
- `if_wait_i`  in  1  instruction fetch not complete this cycle.
- `mem_wait_i`  in  1  data-memory access not complete this cycle.
- `pc_ctrl_o`, `if_id_ctrl_o`, `id_ex_ctrl_o`, `ex_mem_ctrl_o`, `mem_wb_ctrl_o`  out  2 each  `CTRL_Wire_Bus` commands.
- `mem_timeout_o`  out  1  sticky memory-timeout flag.
- `stall_cnt_o`, `flush_cnt_o`  out  64 each  performance counters (see Configuration).

Control encoding: `CTRL_STATE_Default` = 2'b00, `CTRL_STATE_Block` = 2'b01, `CTRL_STATE_Bubble` = 2'b10.

## Operation
- FSM with two states: RUN and DROP. The `ctrl` outputs are combinational from the state and the inputs.
- Load-use hazard (`lu`): `ex_is_load_i & ex_wreg_i & (ex_rd_addr_i != 0) & ((id_rs1_used_i & rs1 == rd) | (id_rs2_used_i & rs2 == rd))`.
- RUN: the first matching row applies. Outputs are listed as pc / if_id / id_ex / ex_mem / mem_wb.
  1. `mem_wait_i`: Block / Block / Block / Block / Bubble.
  2. `ex_redirect_i`: Default / Bubble / Bubble / Default / Default. Next state is DROP if `if_wait_i`, else RUN.
  3. `lu`: Block / Block / Bubble / Default / Default.
  4. `if_wait_i`: Block / Bubble / Default / Default / Default.
  5. Otherwise: all Default.
- DROP: the wrong-path fetch issued before the redirect is still outstanding.
  - pc = Block and if_id = Bubble on every DROP cycle.
  - The other three outputs follow the `mem_wait_i` row if it is set, else Default.
  - `ex_redirect_i` and `lu` are ignored in DROP. Both are impossible here because ID and EX hold bubbles.
  - Exit: when `if_wait_i` = 0, the stale response is discarded (IF_ID Bubble) and the next state is RUN.
- Wait counter:
  - 16-bit, counts consecutive `mem_wait_i` cycles and saturates at 65535.
  - Clears on any cycle with `mem_wait_i` = 0.
  - `mem_timeout_o` sets on the edge where the count reaches `MEM_TIMEOUT`, and stays set until `rst`.

## Timing
- Reset (asynchronous, immediate):
  - state = RUN, wait counter = 0, `mem_timeout_o` = 0, perf counters = 0.
  - While `rst` is high: `pc_ctrl_o` = Block and all four register ctrls = Bubble.
- Latency: the `ctrl` outputs respond to inputs in the same cycle (zero latency). State, counter and flags update on the rising edge.
- A load-use hazard costs exactly one bubble cycle: the next cycle the load is in MEM and `lu` drops.
- Simultaneous `mem_wait_i` and `ex_redirect_i`: EX is held, `ex_redirect_i` stays asserted, and the redirect is taken in the first cycle `mem_wait_i` is low.
- Redirect with `if_wait_i` = 0: no DROP; a single cycle of flush.
- `rst` asserted mid-DROP: returns to RUN immediately and discards the drop.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cnt_o` increments on every cycle with `pc_ctrl_o` = Block, excluding reset.
  - `flush_cnt_o` increments on every cycle where the RUN redirect row applies.
  - Both are 64-bit and wrap to 0.
- `PIPE_CTRL_PERF_EN` undefined: both ports exist and are tied to 0, and no counter flops are synthesized.

## Test plan
- Load x5, then `add x6,x5,x1` (rd = 5, rs1 = 5, both used): one cycle of pc/if_id Block and id_ex Bubble, then all Default. Same sequence with rd = 0: no stall.
- `ex_redirect_i` = 1 with `if_wait_i` = 0: one cycle of if_id/id_ex Bubble with pc Default; state stays RUN; `flush_cnt_o` goes 0→1.
- `ex_redirect_i` = 1 with `if_wait_i` held 3 cycles: DROP for 3 cycles with pc Block and if_id Bubble; the stale fetch is bubbled on its return cycle; RUN follows.
- `mem_wait_i` and `ex_redirect_i` held together 4 cycles: pc/if_id/id_ex/ex_mem Block and mem_wb Bubble for 4 cycles; redirect row in cycle 5.
- `MEM_TIMEOUT` = 8 with `mem_wait_i` held 7 cycles: `mem_timeout_o` = 0. Held 8 cycles: sets; stays 1 after `mem_wait_i` drops; clears only on `rst`.
- `rst` pulsed mid-DROP: outputs show Block/Bubble immediately; after release all Default in RUN and counters = 0.
